// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit that
// owns the architectural Hi/Lo registers.
package mips_cpu_muldiv_pkg;

  // Request encodings presented on the op port; 6 and 7 are reserved.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  // Controller states: waiting, iterating, and final sign/write-back.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } muldiv_state_t;

  // Selects which recurrence a single iteration performs.
  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

  // Quotient reported for any divide by zero.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One unsigned iteration of the multiply/divide recurrence.
// Multiply: {acc,sh} is the running product with the multiplier in sh;
// each step conditionally adds the multiplicand and shifts right.
// Divide: acc is the partial remainder, sh shifts out the dividend at the
// top and collects quotient bits at the bottom (restoring division).
module mips_cpu_muldiv_step
  import mips_cpu_muldiv_pkg::*;
(
  input  step_mode_t  mode_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] sh_i,
  input  logic [31:0] operand_i,
  output logic [31:0] acc_o,
  output logic [31:0] sh_o
);

  logic [32:0] mulSum;
  logic [32:0] remShift;
  logic [31:0] divDiff;
  logic        divFits;

  // Evaluate both recurrences and select the one for the active mode.
  // The divide subtraction only needs 32 bits: whenever the shifted
  // remainder reaches 2^32 the true difference is still below the divisor.
  always_comb begin
    mulSum   = {1'b0, acc_i} + (sh_i[0] ? {1'b0, operand_i} : 33'd0);
    remShift = {acc_i, sh_i[31]};
    divDiff  = remShift[31:0] - operand_i;
    divFits  = remShift[32] | (remShift[31:0] >= operand_i);
    if (mode_i == STEP_DIV) begin
      if (divFits) begin
        acc_o = divDiff;
        sh_o  = {sh_i[30:0], 1'b1};
      end else begin
        acc_o = remShift[31:0];
        sh_o  = {sh_i[30:0], 1'b0};
      end
    end else begin
      acc_o = mulSum[32:1];
      sh_o  = {mulSum[0], sh_i[31:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU responder holding Hi/Lo. Signed ops are
// run on magnitudes and corrected in a final FIXUP cycle; Hi/Lo only change
// on MTHI/MTLO acceptance or on a completed, non-aborted operation.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITERS) + 1;

  muldiv_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] aRaw_q, aRaw_d;
  step_mode_t mode_q, mode_d;
  logic negLo_q, negLo_d;
  logic negHi_q, negHi_d;
  logic div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic done_q, done_d;

  logic        signedOp;
  logic        isDivOp;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] stepAcc;
  logic [31:0] stepSh;
  logic [63:0] product;
  logic        lastIter;

  mips_cpu_muldiv_step u_step (
    .mode_i    (mode_q),
    .acc_i     (acc_q),
    .sh_i      (sh_q),
    .operand_i (opnd_q),
    .acc_o     (stepAcc),
    .sh_o      (stepSh)
  );

  // Decode the incoming request and form operand magnitudes for signed ops.
  always_comb begin
    signedOp = (op == OP_MULT) || (op == OP_DIV);
    isDivOp  = (op == OP_DIV) || (op == OP_DIVU);
    aMag     = (signedOp && a[31]) ? (32'd0 - a) : a;
    bMag     = (signedOp && b[31]) ? (32'd0 - b) : b;
    product  = {acc_q, sh_q};
    lastIter = (cnt_q == CNT_W'(ITERS - 1));
  end

  // Next-state logic: accept in IDLE, iterate in CALC, write back in FIXUP;
  // abort wins over both iteration and write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opnd_d  = opnd_q;
    aRaw_d  = aRaw_q;
    mode_d  = mode_q;
    negLo_d = negLo_q;
    negHi_d = negHi_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = ST_CALC;
              cnt_d   = '0;
              acc_d   = '0;
              mode_d  = isDivOp ? STEP_DIV : STEP_MUL;
              sh_d    = isDivOp ? aMag : bMag;
              opnd_d  = isDivOp ? bMag : aMag;
              aRaw_d  = a;
              negLo_d = signedOp & (a[31] ^ b[31]);
              negHi_d = signedOp & a[31];
              div0_d  = isDivOp & (b == 32'd0);
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = stepAcc;
          sh_d  = stepSh;
          cnt_d = cnt_q + CNT_W'(1);
          if (lastIter) begin
            state_d = ST_FIXUP;
          end
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (mode_q == STEP_MUL) begin
            {hi_d, lo_d} = negLo_q ? (64'd0 - product) : product;
          end else if (div0_q) begin
            lo_d = DIV0_QUOT;
            hi_d = aRaw_q;
          end else begin
            lo_d = negLo_q ? (32'd0 - sh_q) : sh_q;
            hi_d = negHi_q ? (32'd0 - acc_q) : acc_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
      aRaw_q  <= '0;
      mode_q  <= STEP_MUL;
      negLo_q <= 1'b0;
      negHi_q <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opnd_q  <= opnd_d;
      aRaw_q  <= aRaw_d;
      mode_q  <= mode_d;
      negLo_q <= negLo_d;
      negHi_q <= negHi_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed testbench for mips_cpu_muldiv: hand-computed Hi/Lo results,
// latency, busy window, MTHI/MTLO, abort and asynchronous reset behaviour.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  mips_cpu_muldiv #(.ITERS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present one request for one accepting edge; returns 1 time unit after it.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    op_valid = 1'b1;
    op       = opIn;
    a        = aIn;
    b        = bIn;
    @(posedge clk); #1;
    op_valid = 1'b0;
    abort    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 3'(($urandom % 4));
  endtask

  // Wait for done, counting edges since the accept edge and busy samples.
  task automatic waitDone(output int edges, output int busyCnt, output bit held);
    logic [31:0] h0;
    logic [31:0] l0;
    h0      = hi;
    l0      = lo;
    edges   = 0;
    busyCnt = busy ? 1 : 0;
    held    = 1'b1;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busyCnt++;
      if (!done && (hi !== h0 || lo !== l0)) held = 1'b0;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] opIn, input logic [31:0] aIn,
                       input logic [31:0] bIn, input logic [31:0] expHi, input logic [31:0] expLo);
    int  edges;
    int  busyCnt;
    bit  held;
    applyStimulus(opIn, aIn, bIn);
    waitDone(edges, busyCnt, held);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd33);
    checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'd33);
    checkOutput({tag, "_held"}, 32'(held), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_ready"}, 32'(op_ready), 32'd1);
    checkOutput({tag, "_hi"}, hi, expHi);
    checkOutput({tag, "_lo"}, lo, expLo);
    @(posedge clk); #1;
    checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int edges;
    int busyCnt;
    int doneCnt;
    bit held;
    logic [31:0] hiSave;
    logic [31:0] loSave;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    op_valid = 1'b0;
    op       = 3'd0;
    a        = 32'd0;
    b        = 32'd0;
    abort    = 1'b0;

    // Reset state
    @(posedge clk); #1;
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(op_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Arithmetic vectors
    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("mult_mixed", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    runOp("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    runOp("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    runOp("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    runOp("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI / MTLO / reserved op
    applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mthi_done", 32'(done), 32'd0);
    checkOutput("mthi_busy", 32'(busy), 32'd0);
    applyStimulus(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    checkOutput("mtlo_lo", lo, 32'hCAFE_F00D);
    checkOutput("mtlo_hi", hi, 32'h1234_5678);
    applyStimulus(3'd6, 32'h5555_AAAA, 32'h1);
    checkOutput("rsvd_hi", hi, 32'h1234_5678);
    checkOutput("rsvd_lo", lo, 32'hCAFE_F00D);
    checkOutput("rsvd_ready", 32'(op_ready), 32'd1);

    // Request held during busy is only taken once op_ready returns
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    op_valid = 1'b1;
    op       = OP_MTHI;
    a        = 32'hDEAD_BEEF;
    waitDone(edges, busyCnt, held);
    checkOutput("hold_latency", 32'(edges), 32'd33);
    checkOutput("hold_held", 32'(held), 32'd1);
    checkOutput("hold_hi", hi, 32'd2);
    checkOutput("hold_lo", lo, 32'd14);
    @(posedge clk); #1;
    op_valid = 1'b0;
    checkOutput("hold_mthi", hi, 32'hDEAD_BEEF);
    checkOutput("hold_donepulse", 32'(done), 32'd0);

    // Abort in CALC
    hiSave = hi;
    loSave = lo;
    applyStimulus(OP_MULT, 32'd3, 32'd4);
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(op_ready), 32'd1);
    doneCnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkOutput("abort_nodone", 32'(doneCnt), 32'd0);
    checkOutput("abort_hi", hi, hiSave);
    checkOutput("abort_lo", lo, loSave);

    // Abort in FIXUP beats write-back
    applyStimulus(OP_MULTU, 32'd9, 32'd9);
    repeat (32) begin @(posedge clk); #1; end
    checkOutput("fixabort_busy_pre", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("fixabort_done", 32'(done), 32'd0);
    checkOutput("fixabort_ready", 32'(op_ready), 32'd1);
    checkOutput("fixabort_hi", hi, hiSave);
    checkOutput("fixabort_lo", lo, loSave);

    // abort together with op_valid in IDLE: request still accepted
    abort = 1'b1;
    runOp("idleabort", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    // Asynchronous reset mid-operation
    applyStimulus(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
    applyStimulus(OP_MULT, 32'd1000, 32'd1000);
    repeat (19) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_hi", hi, 32'd0);
    checkOutput("arst_lo", lo, 32'd0);
    checkOutput("arst_ready", 32'(op_ready), 32'd1);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Operation after reset still works
    runOp("post_rst", OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
